// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: assembles a byte-serial feature frame into a parallel bus and
// samples the tree class after a settle interval, with a valid/ready result handshake.
module dtree_feature_loader #(
  parameter int NUM_FEATURES  = 5,
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEAT_W-1:0]              in_data,
  input  logic                           in_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_W-1:0]             out_class,
  output logic                           err_frame,
  output logic [15:0]                    frame_cnt
);
  localparam int IW = NUM_FEATURES > 1 ? $clog2(NUM_FEATURES) : 1;
  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEATURES - 1);
  localparam logic [TW-1:0] SETTLE_INIT = TW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] SETTLE_DONE = TW'(1);
  typedef enum logic [1:0] {LOAD, SETTLE, HOLD, DRAIN} state_t;
  state_t                               state_q;
  logic [IW-1:0]                        idx_q;
  logic [TW-1:0]                        cnt_q;
  logic [NUM_FEATURES-1:0][FEAT_W-1:0]  feat_q;
  logic                                 out_valid_q;
  logic                                 err_frame_q;
  logic [CLASS_W-1:0]                   out_class_q;
  logic [15:0]                          frame_cnt_q;
  assign in_ready  = state_q == LOAD || state_q == DRAIN;
  assign feat_bus  = feat_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign err_frame = err_frame_q;
  assign frame_cnt = frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      feat_q      <= '0;
      out_valid_q <= 1'b0;
      err_frame_q <= 1'b0;
      out_class_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      err_frame_q <= 1'b0;
      case (state_q)
        LOAD: if (in_valid) begin
          feat_q[idx_q] <= in_data;
          if (idx_q == LAST_IDX) begin
            // A full slot set ends the frame; a missing in_last means the frame is too long.
            idx_q       <= '0;
            cnt_q       <= SETTLE_INIT;
            err_frame_q <= !in_last;
            state_q     <= in_last ? SETTLE : DRAIN;
          end else if (in_last) begin
            idx_q       <= '0;
            err_frame_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SETTLE_DONE) begin
            out_class_q <= tree_class;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
          state_q     <= LOAD;
        end
        DRAIN: if (in_valid && in_last) state_q <= LOAD;
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb_dtree_feature_loader: directed bench with a result scoreboard for dtree_feature_loader.
module tb_dtree_feature_loader;
  localparam int NF = 5;
  localparam int FW = 8;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic [CW-1:0] tree_class = '0;
  logic in_ready, out_valid, err_frame;
  logic [NF*FW-1:0] feat_bus;
  logic [CW-1:0] out_class;
  logic [15:0] frame_cnt;
  typedef struct packed {
    logic [CW-1:0]    cls;
    logic [NF*FW-1:0] feat;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ov_cnt = 0;
  logic [15:0] exp_fc = '0;

  dtree_feature_loader #(.NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .feat_bus(feat_bus), .tree_class(tree_class), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF*FW-1:0] frame(input logic [7:0] base, input logic [7:0] step);
    logic [NF*FW-1:0] f;
    for (int i = 0; i < NF; i++) f[i*FW +: FW] = base + 8'(i) * step;
    return f;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (err_frame) err_cnt++;
    if (out_valid) ov_cnt++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_depth", 64'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        check("out_class", out_class, e.cls);
        check("feat_bus_hold", feat_bus, e.feat);
      end
      check("frame_cnt_pre", frame_cnt, exp_fc);
      exp_fc++;
    end
  end

  task automatic send(input int n, input logic [7:0] base, input logic [7:0] step, input int last_at);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      int t;
      logic ok;
      t = 0;
      in_valid = 1'b1;
      in_data  = base + 8'(i) * step;
      in_last  = (i == last_at);
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end while (!ok && t < 50);
      if (!ok) check("accept_timeout", ok, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int e0, o0, t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_feat_bus", feat_bus, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_out_class", out_class, 0);
    // nominal frame and result timing
    tree_class = 2'b01;
    out_ready  = 1'b1;
    sb.push_back('{cls: 2'b01, feat: frame(8'h10, 8'h10)});
    send(5, 8'h10, 8'h10, 4);
    @(negedge clk);
    check("nom_ov_t0", out_valid, 0);
    check("nom_in_ready_settle", in_ready, 0);
    check("nom_feat_bus", feat_bus, 40'h5040302010);
    @(negedge clk);
    check("nom_ov_t1", out_valid, 0);
    @(negedge clk);
    check("nom_ov_t2", out_valid, 1);
    @(negedge clk);
    check("nom_ov_t3", out_valid, 0);
    check("nom_in_ready_after", in_ready, 1);
    check("nom_frame_cnt", frame_cnt, 1);
    // backpressure with tree_class changing during HOLD
    out_ready = 1'b0;
    sb.push_back('{cls: 2'b01, feat: frame(8'h11, 8'h11)});
    send(5, 8'h11, 8'h11, 4);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    check("bp_ov_rise", out_valid, 1);
    tree_class = 2'b11;
    in_valid   = 1'b1;
    in_data    = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_class", out_class, 2'b01);
      check("bp_feat_bus", feat_bus, 40'h5544332211);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_ov_drop", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_frame_cnt", frame_cnt, 2);
    // short frame, then a good frame
    e0 = err_cnt;
    o0 = ov_cnt;
    send(3, 8'hA1, 8'h01, 2);
    repeat (4) @(negedge clk);
    check("short_err_pulses", 64'(err_cnt - e0), 1);
    check("short_no_result", 64'(ov_cnt - o0), 0);
    check("short_feat_bus", feat_bus, 40'h5544A3A2A1);
    check("short_in_ready", in_ready, 1);
    tree_class = 2'b10;
    sb.push_back('{cls: 2'b10, feat: frame(8'h60, 8'h01)});
    send(5, 8'h60, 8'h01, 4);
    drain();
    check("short_next_frame_cnt", frame_cnt, 3);
    // long frame: error after the fifth beat, remaining beats drained
    e0 = err_cnt;
    o0 = ov_cnt;
    send(5, 8'h01, 8'h01, -1);
    @(negedge clk);
    check("long_err_pulse", err_frame, 1);
    check("long_drain_ready", in_ready, 1);
    send(2, 8'h06, 8'h01, 1);
    repeat (4) @(negedge clk);
    check("long_err_pulses", 64'(err_cnt - e0), 1);
    check("long_no_result", 64'(ov_cnt - o0), 0);
    check("long_feat_bus", feat_bus, 40'h0504030201);
    check("long_in_ready", in_ready, 1);
    tree_class = 2'b11;
    sb.push_back('{cls: 2'b11, feat: frame(8'h70, 8'h02)});
    send(5, 8'h70, 8'h02, 4);
    drain();
    check("long_next_frame_cnt", frame_cnt, 4);
    // reset while settling
    o0 = ov_cnt;
    send(5, 8'h80, 8'h01, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fc = '0;
    @(negedge clk);
    check("rst_mid_feat_bus", feat_bus, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    check("rst_mid_no_result", 64'(ov_cnt - o0), 0);
    check("rst_mid_err", 64'(err_cnt - e0), 1);
    // frame counter wrap
    @(posedge clk); #1;
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    exp_fc = 16'hFFFF;
    @(negedge clk);
    check("wrap_preload", frame_cnt, 16'hFFFF);
    tree_class = 2'b01;
    sb.push_back('{cls: 2'b01, feat: frame(8'h90, 8'h03)});
    send(5, 8'h90, 8'h03, 4);
    drain();
    check("wrap_frame_cnt", frame_cnt, 16'h0000);
    check("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
